// File: rtl/i2s_tx.sv
// Mono I2S serializer for the CS4344: one sample per 2048-clk frame, sent on both halves, MSB 32 clk after load.
// Single-entry pending buffer; sample_ready drops once it is full and rises again on the next frame load.
module i2s_tx #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] sample,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              sample_tick,
  output logic              underrun,
  output logic              mclk,
  output logic              lrck,
  output logic              sclk,
  output logic              sdata
);

  localparam logic [4:0] DW5 = 5'(DATA_W);

  logic [10:0]       cnt;
  logic [10:0]       cnt_nxt;
  logic [DATA_W-1:0] word;
  logic [DATA_W-1:0] pend;
  logic              pend_full;
  logic              frame_load;
  logic              accept;
  logic [4:0]        slot;
  logic [4:0]        bit_idx;
  logic              bit_on;
  logic              wbit;

  assign cnt_nxt      = cnt + 11'd1;
  assign frame_load   = (cnt == 11'd2047);
  assign sample_ready = !pend_full;
  assign accept       = sample_valid && !pend_full;

  // Outputs are registered from the upcoming count so they line up with cnt itself.
  assign slot    = cnt_nxt[9:5];
  assign bit_on  = (slot != 5'd0) && (slot <= DW5);
  assign bit_idx = DW5 - slot;

  always_comb begin
    wbit = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (bit_idx == 5'(i)) wbit = word[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt         <= '0;
      mclk        <= 1'b0;
      sclk        <= 1'b0;
      lrck        <= 1'b0;
      sdata       <= 1'b0;
      sample_tick <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      cnt         <= cnt_nxt;
      mclk        <= cnt_nxt[1];
      sclk        <= cnt_nxt[4];
      lrck        <= cnt_nxt[10];
      sdata       <= bit_on & wbit;
      sample_tick <= frame_load;
      underrun    <= frame_load && !pend_full && !accept;
    end
  end

  // On a frame load an empty buffer lets a same-cycle sample bypass straight into word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word      <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
    end else if (frame_load) begin
      pend_full <= 1'b0;
      if (pend_full) begin
        word <= pend;
      end else if (accept) begin
        word <= sample;
      end
    end else if (accept) begin
      pend      <= sample;
      pend_full <= 1'b1;
    end
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx: queue-based sample model, sdata decoded per LRCK half on SCLK rising edges.
module tb_i2s_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sample = '0;
  logic        sample_valid = 1'b0;
  logic        sample_ready;
  logic        sample_tick;
  logic        underrun;
  logic        mclk;
  logic        lrck;
  logic        sclk;
  logic        sdata;

  i2s_tx #(.DATA_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (sample),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .sample_tick  (sample_tick),
    .underrun     (underrun),
    .mclk         (mclk),
    .lrck         (lrck),
    .sclk         (sclk),
    .sdata        (sdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: tt = clk edges since reset release, mq = samples taken but not yet playing.
  int          tt = 0;
  logic [15:0] cur = '0;
  logic [15:0] mq[$];
  int          sched_t[$];
  logic [15:0] sched_v[$];
  logic        exp_tick = 1'b0;
  logic        exp_under = 1'b0;

  function automatic logic [31:0] slots_of(input logic [15:0] w);
    slots_of = {16'h0000, w} << 15;
  endfunction

  task automatic drive_update();
    if (sched_t.size() > 0 && tt >= sched_t[0]) begin
      sample_valid = 1'b1;
      sample       = sched_v[0];
    end else begin
      sample_valid = 1'b0;
      sample       = '0;
    end
  endtask

  task automatic offer(input int at, input logic [15:0] v);
    sched_t.push_back(at);
    sched_v.push_back(v);
    drive_update();
  endtask

  // Advance one clock from a negedge to the next negedge, updating the model.
  task automatic step();
    logic        acc;
    logic        ld;
    int          dt;
    logic [15:0] dv;
    acc = sample_valid && (mq.size() == 0);
    ld  = (tt % 2048) == 2047;
    @(posedge clk);
    if (acc) begin
      mq.push_back(sample);
      dt = sched_t.pop_front();
      dv = sched_v.pop_front();
    end
    exp_tick  = ld;
    exp_under = 1'b0;
    if (ld) begin
      if (mq.size() > 0) cur = mq.pop_front();
      else exp_under = 1'b1;
    end
    tt++;
    @(negedge clk);
    drive_update();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sched_t.delete();
    sched_v.delete();
    mq.delete();
    drive_update();
    repeat (3) @(negedge clk);
    rst_n     = 1'b1;
    tt        = 0;
    cur       = '0;
    exp_tick  = 1'b0;
    exp_under = 1'b0;
  endtask

  task automatic wait_frame_start();
    for (int i = 0; i < 2048 && (tt % 2048) != 0; i++) step();
  endtask

  // Runs one whole frame from a frame start; returns both decoded halves and pulse counts.
  task automatic capture_frame(output logic [31:0] l, output logic [31:0] r,
                               output int nt, output int nu, output logic eu);
    l = '0; r = '0; nt = 0; nu = 0; eu = 1'b0;
    for (int i = 0; i < 2048; i++) begin
      if (i % 32 == 16) begin
        if (i < 1024) l = {l[30:0], sdata};
        else          r = {r[30:0], sdata};
      end
      step();
      if (sample_tick) nt++;
      if (underrun) nu++;
      if (exp_tick) eu = exp_under;
    end
  endtask

  task automatic test_reset();
    logic [6:0] obs;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = {mclk, lrck, sclk, sdata, sample_tick, underrun, sample_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000001", obs);
    end
    rst_n     = 1'b1;
    tt        = 0;
    cur       = '0;
    exp_tick  = 1'b0;
    exp_under = 1'b0;
    #1;
    obs = {mclk, lrck, sclk, sdata, sample_tick, underrun, sample_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_release_outputs got %b want 0000001", obs);
    end
  endtask

  task automatic test_idle();
    logic [6:0] obs;
    logic [6:0] exp;
    int         nt = 0;
    for (int i = 0; i < 4096; i++) begin
      step();
      obs = {mclk, sclk, lrck, sample_tick, underrun, sdata, sample_ready};
      exp = {tt[1], tt[4], tt[10], (tt % 2048) == 0, (tt % 2048) == 0, 1'b0, 1'b1};
      if (sample_tick) nt++;
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL idle_clocks t=%0d got %b want %b", tt, obs, exp);
      end
    end
    checks++;
    if (nt !== 2) begin
      errors++;
      $display("FAIL idle_tick_count got %0d want 2", nt);
    end
  endtask

  task automatic test_single();
    logic [31:0] l, r;
    int          nt, nu;
    logic        eu;
    wait_frame_start();
    offer(tt + 10, 16'hA5F0);
    capture_frame(l, r, nt, nu, eu);
    checks++;
    if (nu !== 0) begin
      errors++;
      $display("FAIL single_underrun got %0d want 0", nu);
    end
    checks++;
    if (nt !== 1) begin
      errors++;
      $display("FAIL single_tick got %0d want 1", nt);
    end
    capture_frame(l, r, nt, nu, eu);
    checks++;
    if (l !== slots_of(16'hA5F0)) begin
      errors++;
      $display("FAIL single_left got %h want %h", l, slots_of(16'hA5F0));
    end
    checks++;
    if (r !== slots_of(16'hA5F0)) begin
      errors++;
      $display("FAIL single_right got %h want %h", r, slots_of(16'hA5F0));
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] l, r;
    int          nt, nu;
    logic        eu;
    int          f;
    wait_frame_start();
    f = tt;
    offer(f + 100, 16'h1234);
    offer(f + 100, 16'h5678);
    while (tt < f + 100) step();
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready_before got %b want 1", sample_ready);
    end
    step();
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_after got %b want 0", sample_ready);
    end
    repeat (500) step();
    checks++;
    if (sample_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ready_held got %b want 0", sample_ready);
    end
    wait_frame_start();
    checks++;
    if ({sample_tick, underrun} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_load_pulses got %b want 10", {sample_tick, underrun});
    end
    capture_frame(l, r, nt, nu, eu);
    checks++;
    if ({l, r} !== {slots_of(16'h1234), slots_of(16'h1234)}) begin
      errors++;
      $display("FAIL b2b_first_word got %h %h want %h", l, r, slots_of(16'h1234));
    end
    checks++;
    if (nu !== 0) begin
      errors++;
      $display("FAIL b2b_first_underrun got %0d want 0", nu);
    end
    capture_frame(l, r, nt, nu, eu);
    checks++;
    if ({l, r} !== {slots_of(16'h5678), slots_of(16'h5678)}) begin
      errors++;
      $display("FAIL b2b_second_word got %h %h want %h", l, r, slots_of(16'h5678));
    end
  endtask

  task automatic test_bypass();
    logic [31:0] l, r;
    int          nt, nu;
    logic        eu;
    int          f;
    wait_frame_start();
    f = tt;
    offer(f + 2047, 16'h7FFF);
    while (tt < f + 2047) step();
    checks++;
    if (sample_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_ready_before got %b want 1", sample_ready);
    end
    step();
    checks++;
    if ({sample_tick, underrun, sample_ready} !== 3'b101) begin
      errors++;
      $display("FAIL bypass_load got %b want 101", {sample_tick, underrun, sample_ready});
    end
    capture_frame(l, r, nt, nu, eu);
    checks++;
    if ({l, r} !== {slots_of(16'h7FFF), slots_of(16'h7FFF)}) begin
      errors++;
      $display("FAIL bypass_word got %h %h want %h", l, r, slots_of(16'h7FFF));
    end
  endtask

  task automatic test_repeat();
    logic [31:0] l, r;
    int          nt, nu;
    logic        eu;
    wait_frame_start();
    offer(tt + 300, 16'h8001);
    capture_frame(l, r, nt, nu, eu);
    for (int k = 0; k < 3; k++) begin
      capture_frame(l, r, nt, nu, eu);
      checks++;
      if ({l, r} !== {slots_of(16'h8001), slots_of(16'h8001)}) begin
        errors++;
        $display("FAIL repeat_word frame %0d got %h %h want %h", k, l, r, slots_of(16'h8001));
      end
      checks++;
      if ({nt, nu} !== {32'd1, 32'd1}) begin
        errors++;
        $display("FAIL repeat_pulses frame %0d got tick %0d underrun %0d want 1 1", k, nt, nu);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] l, r;
    int          nt, nu;
    logic        eu;
    logic [15:0] w;
    int          t1;
    int          n;
    for (int k = 0; k < 6; k++) begin
      wait_frame_start();
      w = cur;
      n = int'($urandom_range(0, 2));
      t1 = tt + int'($urandom_range(0, 2047));
      if (k == 2) t1 = tt + 2047;
      for (int j = 0; j < n; j++) begin
        offer(t1, 16'($urandom));
        t1 = t1 + int'($urandom_range(0, 40));
      end
      capture_frame(l, r, nt, nu, eu);
      checks++;
      if ({l, r} !== {slots_of(w), slots_of(w)}) begin
        errors++;
        $display("FAIL random_word frame %0d got %h %h want %h", k, l, r, slots_of(w));
      end
      checks++;
      if (nu !== int'(eu)) begin
        errors++;
        $display("FAIL random_underrun frame %0d got %0d want %0d", k, nu, eu);
      end
      checks++;
      if (nt !== 1) begin
        errors++;
        $display("FAIL random_tick frame %0d got %0d want 1", k, nt);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] l, r;
    int          nt, nu;
    logic        eu;
    logic [6:0]  obs;
    wait_frame_start();
    offer(tt + 100, 16'hBEEF);
    repeat (700) step();
    checks++;
    if ({sample_ready, mq.size() == 0} !== 2'b00) begin
      errors++;
      $display("FAIL midreset_ready_before got %b want 0", sample_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    obs = {mclk, lrck, sclk, sdata, sample_tick, underrun, sample_ready};
    checks++;
    if (obs !== 7'b0000001) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 0000001", obs);
    end
    sched_t.delete();
    sched_v.delete();
    mq.delete();
    drive_update();
    repeat (2) @(negedge clk);
    rst_n     = 1'b1;
    tt        = 0;
    cur       = '0;
    exp_tick  = 1'b0;
    exp_under = 1'b0;
    capture_frame(l, r, nt, nu, eu);
    checks++;
    if ({l, r} !== 64'h0) begin
      errors++;
      $display("FAIL midreset_word got %h %h want 0", l, r);
    end
    checks++;
    if (nu !== 1) begin
      errors++;
      $display("FAIL midreset_underrun got %0d want 1", nu);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog timeout checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_single();
    test_back_to_back();
    test_bypass();
    test_repeat();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/i2s_tx.md
# i2s_tx

Mono I2S transmitter for the PmodI2S (CS4344 DAC). It sits directly downstream of the RAM playback path and takes the 16-bit sample stream read back from the async SRAM controller. It serializes that stream at fs = 100 MHz / 2048 ≈ 48.828 kHz and drives MCLK, LRCK, SCLK and SDIN on JA[3:0]. It also exports a one-cycle sample tick, which upstream oscillators use as their sample-rate enable instead of sampling a Pmod pin.

## Interface
Parameters:
- DATA_W, 16, sample width in bits; legal range 8..24; sent MSB-first in a 32-bit slot.

Ports:
- clk  in  1  100 MHz system clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- sample  in  DATA_W  two's-complement audio sample.
- sample_valid  in  1  sample is offered this cycle.
- sample_ready  out  1  the block accepts the offered sample this cycle.
- sample_tick  out  1  one-cycle pulse on every frame-load edge (fs rate).
- underrun  out  1  one-cycle pulse on a frame-load edge when no new sample was available.
- mclk  out  1  DAC master clock, clk/4 = 25 MHz; drives JA[0].
- lrck  out  1  word select: 0 = left, 1 = right; fs rate; drives JA[1].
- sclk  out  1  serial bit clock, clk/32 = 64·fs; drives JA[2].
- sdata  out  1  serial data, I2S format; drives JA[3].

## Operation
- Free-running 11-bit counter `cnt`, incremented every clk and wrapping 2047→0.
- Every output is a register. Each output is computed from the next value of `cnt` and updates on the same edge as `cnt`:
  - mclk = cnt[1]
  - sclk = cnt[4]
  - lrck = cnt[10]
- The frame-load edge is the edge on which `cnt` goes 2047→0.
- The slot index is s = cnt[9:5] (0..31) within each LRCK half.
- Bit value per slot:
  - slots 1..DATA_W: sdata = word[DATA_W−s];
  - slot 0 and slots DATA_W+1..31: sdata = 0.
- The same `word` is sent on both left and right (mono). Format is standard I2S: MSB one SCLK after the LRCK transition.
- Sample buffering:
  - A single-entry pending buffer `pend`/`pend_full` holds the next sample.
  - sample_ready = !pend_full.
  - A sample is accepted when sample_valid && sample_ready.
- On the frame-load edge:
  - If pend_full: word ← pend, and pend_full ← 0.
  - Else, if a sample is accepted on this same edge: word ← sample (bypass); pend is not written.
  - Else: word holds its previous value (repeat last sample), and underrun pulses.
  - sample_tick pulses on every frame-load edge, whatever the buffer state.
- An acceptance on any other edge writes pend and sets pend_full.
- When pend_full = 1, sample_valid is ignored and the upstream stage must hold its sample.
- Reset (asynchronous, applies immediately, including mid-frame):
  - cnt = 0, word = 0, pend = 0, pend_full = 0.
  - mclk, lrck, sclk, sdata, sample_tick and underrun all = 0.
  - sample_ready = 1 while rst_n is low and after reset release; this follows directly from pend_full = 0.
- Release from reset starts a new frame at cnt = 0 with lrck = 0. No partial word is ever emitted.

## Timing
- SCLK falls at every `cnt` value that is a multiple of 32. sdata and lrck change only on those edges; the DAC samples on the SCLK rising edge (cnt[4:0] = 16).
- LRCK toggles at cnt = 0 and cnt = 1024, each coincident with an SCLK falling edge.
- Latency from the frame-load edge to the MSB on sdata is 32 clk (slot 1 of the left half).
- Latency from acceptance into an empty pend to the MSB on sdata is at most 2048 + 32 clk.
- At most one sample is consumed per 2048 clk.
- Throughput with continuous sample_valid: one handshake per frame. After reset the first acceptance fills pend, and sample_ready then stays low until the next frame-load edge.
- sample_tick and underrun are high for exactly 1 clk. When both fire, they are on the same edge.

## Test plan
- Reset, then run 4096 clk with no samples → mclk period 4, sclk period 32, lrck period 2048. lrck is low for cnt 0..1023. sdata stays 0. sample_tick pulses at clk 2048 and 4096. underrun pulses on each of those ticks.
- Accept 0xA5F0 at clk 10, then decode sdata on sclk rising edges → left and right halves of the next frame each read 0xA5F0 in slots 1..16 and zeros in slots 0 and 17..31. underrun does not pulse on that frame-load edge.
- Offer 0x1234, then 0x5678 back-to-back in mid-frame → 0x1234 is accepted. sample_ready drops and 0x5678 is held until the frame-load edge. The next frame sends 0x1234 and the frame after sends 0x5678.
- Hold pend empty and assert sample_valid with 0x7FFF exactly on the 2047→0 edge → bypass load. That frame sends 0x7FFF, with no underrun pulse, and pend_full stays 0.
- Send 0x8001 for one frame, then withhold samples → subsequent frames repeat 0x8001, and underrun pulses once per frame.
- Assert rst_n low at cnt = 700 mid-word → all outputs go to 0 at once and sample_ready goes to 1. After release the first MSB appears 32 clk later with word = 0. The previous sample is not resumed.
